// File: rtl/dsp_pkg.sv
// dsp_pkg: shared DSP display types and constants.
package dsp_pkg;
    typedef enum logic {S_EMPTY, S_LOCKED} state_t;
    localparam logic [3:0] DIGIT_NONE = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // active-low {g,f,e,d,c,b,a} for digits 0..9
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: registered 4-bit to active-low 7-segment decoder with blanking.
module seg7_decode
    import dsp_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] iDigit,
    input  logic       iBlank,
    output logic [6:0] oSeg
);
    always_ff @(posedge CLK) begin
        if (!RST)
            oSeg <= SEG_BLANK;
        else
            oSeg <= (iBlank || iDigit > 4'd9) ? SEG_BLANK : SEG_TABLE[iDigit];
    end
endmodule

// File: rtl/digit_result_filter.sv
// digit_result_filter: per-frame debounce of recognised digits with timeout blanking.
module digit_result_filter
    import dsp_pkg::*;
#(
    parameter int STABLE_FRAMES  = 3,
    parameter int TIMEOUT_FRAMES = 8,
    parameter int CNT_W          = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       iDigital,
    input  logic             iValid,
    input  logic             iFrameStart,
    input  logic             iHold,
    output logic [3:0]       oDigit,
    output logic             oDigitValid,
    output logic             oChange,
    output logic [CNT_W-1:0] oMatchCnt,
    output logic [6:0]       oHEX
);
    localparam logic [CNT_W-1:0] STABLE  = CNT_W'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_FRAMES);

    state_t           state;
    logic             fsD;
    logic [3:0]       cand;
    logic [CNT_W-1:0] matchCnt, missCnt, nextMatch, nextMiss;
    logic             tick, sample, hit, commit, clear;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

    // FSM decisions look at the post-update counts so commit/clear land on the tick edge
    always_comb begin
        tick      = iFrameStart & ~fsD;
        sample    = tick & ~iHold;
        hit       = iValid && iDigital <= 4'd9;
        nextMatch = !sample ? matchCnt :
                    !hit ? '0 :
                    (iDigital == cand && matchCnt != '0) ? satInc(matchCnt, STABLE) : CNT_W'(1);
        nextMiss  = !sample ? missCnt : hit ? '0 : satInc(missCnt, TIMEOUT);
        commit    = sample && hit && nextMatch == STABLE && (state == S_EMPTY || iDigital != oDigit);
        clear     = sample && !hit && state == S_LOCKED && nextMiss == TIMEOUT;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= S_EMPTY;
            fsD         <= 1'b0;
            cand        <= '0;
            matchCnt    <= '0;
            missCnt     <= '0;
            oDigit      <= DIGIT_NONE;
            oDigitValid <= 1'b0;
            oChange     <= 1'b0;
        end else begin
            fsD      <= iFrameStart;
            matchCnt <= nextMatch;
            missCnt  <= nextMiss;
            oChange  <= commit | clear;
            if (sample && hit)
                cand <= iDigital;
            if (commit) begin
                state       <= S_LOCKED;
                oDigit      <= iDigital;
                oDigitValid <= 1'b1;
            end else if (clear) begin
                state       <= S_EMPTY;
                oDigit      <= DIGIT_NONE;
                oDigitValid <= 1'b0;
            end
        end
    end

    assign oMatchCnt = matchCnt;

    seg7_decode uSeg (
        .CLK    (CLK),
        .RST    (RST),
        .iDigit (oDigit),
        .iBlank (!oDigitValid),
        .oSeg   (oHEX)
    );
endmodule

// File: tb/tb_digit_result_filter.sv
// tb_digit_result_filter: vector table, corner sequences and random frames against a run-length model.
module tb_digit_result_filter;
    localparam int STABLE = 3;
    localparam int TIMEOUT = 8;

    logic       CLK = 0;
    logic       RST = 0;
    logic [3:0] iDigital = 0;
    logic       iValid = 0;
    logic       iFrameStart = 0;
    logic       iHold = 0;
    logic [3:0] oDigit;
    logic       oDigitValid;
    logic       oChange;
    logic [3:0] oMatchCnt;
    logic [6:0] oHEX;

    digit_result_filter #(.STABLE_FRAMES(STABLE), .TIMEOUT_FRAMES(TIMEOUT), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .iDigital(iDigital), .iValid(iValid), .iFrameStart(iFrameStart),
        .iHold(iHold), .oDigit(oDigit), .oDigitValid(oDigitValid), .oChange(oChange),
        .oMatchCnt(oMatchCnt), .oHEX(oHEX)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic v; logic [3:0] d; logic h;
        logic [3:0] eDig; logic eVal; logic [3:0] eCnt; logic eChg;
    } vec_t;
    vec_t tbl[$];

    int nChecks = 0;
    int nFail = 0;

    // model: unsaturated run lengths of identical hits and of misses
    int runLen, missLen;
    logic [3:0] runDig, comDig;
    logic comValid, mChg;

    function automatic logic [6:0] segOf(input logic val, input logic [3:0] d);
        if (!val) return 7'h7F;
        case (d)
            4'd0: return 7'h40; 4'd1: return 7'h79; 4'd2: return 7'h24; 4'd3: return 7'h30;
            4'd4: return 7'h19; 4'd5: return 7'h12; 4'd6: return 7'h02; 4'd7: return 7'h78;
            4'd8: return 7'h00; 4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        runLen = 0; missLen = 0; runDig = 0; comDig = 4'hF; comValid = 0; mChg = 0;
    endtask

    task automatic modelStep(input logic v, input logic [3:0] d, input logic h);
        mChg = 0;
        if (!h) begin
            if (v && d <= 9) begin
                missLen = 0;
                if (runLen > 0 && d == runDig) runLen++;
                else begin runDig = d; runLen = 1; end
                if (runLen >= STABLE && (!comValid || d != comDig)) begin
                    comValid = 1; comDig = d; mChg = 1;
                end
            end else begin
                runLen = 0;
                missLen++;
                if (comValid && missLen >= TIMEOUT) begin comValid = 0; mChg = 1; end
            end
        end
    endtask

    task automatic checkModel(input string tag);
        chk({tag, " oDigit"}, oDigit, comValid ? comDig : 4'hF);
        chk({tag, " oDigitValid"}, oDigitValid, comValid);
        chk({tag, " oMatchCnt"}, oMatchCnt, runLen > STABLE ? STABLE : runLen);
        chk({tag, " oChange"}, oChange, mChg);
    endtask

    task automatic applyFrame(input logic v, input logic [3:0] d, input logic h);
        iValid = v; iDigital = d; iHold = h; iFrameStart = 1;
        @(posedge CLK); #1;
        iFrameStart = 0;
        modelStep(v, d, h);
    endtask

    task automatic finishFrame(input string tag, input logic [6:0] expHex);
        @(posedge CLK); #1;
        chk({tag, " oChange low"}, oChange, 0);
        chk({tag, " oHEX"}, oHEX, expHex);
    endtask

    initial begin
        // reset and idle outputs
        repeat (2) @(posedge CLK);
        #1 RST = 1;
        chk("reset oDigit", oDigit, 4'hF);
        chk("reset oDigitValid", oDigitValid, 0);
        chk("reset oHEX", oHEX, 7'h7F);
        chk("reset oMatchCnt", oMatchCnt, 0);
        chk("reset oChange", oChange, 0);
        modelReset();

        tbl.push_back('{1, 7, 0, 4'hF, 0, 1, 0});
        tbl.push_back('{1, 7, 0, 4'hF, 0, 2, 0});
        tbl.push_back('{1, 7, 0, 4'h7, 1, 3, 1});
        tbl.push_back('{1, 7, 0, 4'h7, 1, 3, 0});
        tbl.push_back('{1, 7, 0, 4'h7, 1, 3, 0});
        tbl.push_back('{1, 4, 0, 4'h7, 1, 1, 0});
        tbl.push_back('{1, 4, 0, 4'h7, 1, 2, 0});
        tbl.push_back('{1, 4, 0, 4'h4, 1, 3, 1});
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 0, 4'h4, 1, 0, 0});
        tbl.push_back('{1, 4, 0, 4'h4, 1, 1, 0});
        for (int i = 0; i < 7; i++) tbl.push_back('{0, 0, 0, 4'h4, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 4'hF, 0, 0, 1});
        tbl.push_back('{1, 12, 0, 4'hF, 0, 0, 0});
        for (int i = 0; i < 3; i++) tbl.push_back('{1, 5, 1, 4'hF, 0, 0, 0});
        tbl.push_back('{1, 5, 0, 4'hF, 0, 1, 0});

        foreach (tbl[i]) begin
            applyFrame(tbl[i].v, tbl[i].d, tbl[i].h);
            chk($sformatf("vec%0d oDigit", i), oDigit, tbl[i].eDig);
            chk($sformatf("vec%0d oDigitValid", i), oDigitValid, tbl[i].eVal);
            chk($sformatf("vec%0d oMatchCnt", i), oMatchCnt, tbl[i].eCnt);
            chk($sformatf("vec%0d oChange", i), oChange, tbl[i].eChg);
            finishFrame($sformatf("vec%0d", i), segOf(tbl[i].eVal, tbl[i].eDig));
        end

        // iFrameStart held high: exactly one tick (a hit of 5 continues the run to 2, no commit)
        iValid = 1; iDigital = 5; iHold = 0; iFrameStart = 1;
        @(posedge CLK); #1;
        modelStep(1, 5, 0);
        chk("held hit first oMatchCnt", oMatchCnt, 2);
        repeat (9) @(posedge CLK);
        #1 chk("held hit last oMatchCnt", oMatchCnt, 2);
        chk("held hit oDigitValid", oDigitValid, 0);
        iFrameStart = 0;
        @(posedge CLK); #1;
        iDigital = 12; iFrameStart = 1;
        @(posedge CLK); #1;
        modelStep(1, 12, 0);
        chk("held code12 oMatchCnt", oMatchCnt, 0);
        repeat (9) @(posedge CLK);
        #1 checkModel("held code12");
        iFrameStart = 0;
        @(posedge CLK); #1;

        // lock on 9, back off to match_cnt=2, then reset mid-operation
        for (int i = 0; i < 3; i++) begin applyFrame(1, 9, 0); checkModel("lock9"); finishFrame("lock9", segOf(comValid, comDig)); end
        applyFrame(0, 0, 0); checkModel("lock9 miss"); finishFrame("lock9 miss", segOf(comValid, comDig));
        for (int i = 0; i < 2; i++) begin applyFrame(1, 9, 0); checkModel("lock9 rerun"); finishFrame("lock9 rerun", segOf(comValid, comDig)); end
        chk("pre-reset oMatchCnt", oMatchCnt, 2);
        chk("pre-reset oDigit", oDigit, 9);
        RST = 0; iFrameStart = 1;
        @(posedge CLK); #1;
        modelReset();
        chk("midreset oDigit", oDigit, 4'hF);
        chk("midreset oDigitValid", oDigitValid, 0);
        chk("midreset oMatchCnt", oMatchCnt, 0);
        chk("midreset oChange", oChange, 0);
        chk("midreset oHEX", oHEX, 7'h7F);
        RST = 1;
        applyFrame(1, 9, 0);
        chk("post-reset oMatchCnt", oMatchCnt, 1);
        checkModel("post-reset");
        finishFrame("post-reset", segOf(comValid, comDig));

        // random frames
        for (int i = 0; i < 400; i++) begin
            int r;
            logic v, h;
            logic [3:0] d;
            r = $urandom % 10;
            d = r < 4 ? 4'd2 : r < 7 ? 4'd6 : r < 8 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            v = ($urandom % 6) != 0;
            h = ($urandom % 10) == 0;
            applyFrame(v, d, h);
            checkModel("rand");
            finishFrame("rand", segOf(comValid, comDig));
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
